// File: rtl/multi_axis_step_ctrl.sv
// Purpose: N-axis stepper controller: debounced dir/enable/limit, shared step tick,
//          full/half-step coil sequencing, homed position tracking, soft upper limit.
// Latency: debounced inputs change after DB_CYCLES stable cycles; a step lands on the
//          edge ending a tick cycle and shows on coil/pos/moving the cycle after.
// Backpressure: none; outputs are free-running registered levels.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   dir_in/en_in    raw per-axis direction (1 = away from home) and enable
//   lim_in          raw per-axis home limit switch (1 = pressed)
//   half_step       0 = full-step, 1 = half-step (all axes)
//   coil            axis i at coil[4i+3:4i]; 0000 while the axis is disabled
//   pos             axis i at pos[POS_W*i +: POS_W]
//   moving, homed   axis stepped on the last tick / limit seen since reset
module multi_axis_step_ctrl #(
  parameter int               NUM_AXES  = 2,
  parameter int               STEP_DIV  = 25_000_000,
  parameter int               DB_CYCLES = 1_000_000,
  parameter int               POS_W     = 16,
  parameter logic [POS_W-1:0] POS_MAX   = {POS_W{1'b1}}
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_AXES-1:0]       dir_in,
  input  logic [NUM_AXES-1:0]       en_in,
  input  logic [NUM_AXES-1:0]       lim_in,
  input  logic                      half_step,
  output logic [4*NUM_AXES-1:0]     coil,
  output logic [POS_W*NUM_AXES-1:0] pos,
  output logic [NUM_AXES-1:0]       moving,
  output logic [NUM_AXES-1:0]       homed
);

  localparam int PRE_W = $clog2(STEP_DIV);
  localparam int DB_W  = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam int NDB   = 3 * NUM_AXES;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(STEP_DIV - 1);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DB_CYCLES - 1);

  function automatic logic [3:0] phase_coil(input logic [2:0] p);
    case (p)
      3'd0:    phase_coil = 4'b1000;
      3'd1:    phase_coil = 4'b1100;
      3'd2:    phase_coil = 4'b0100;
      3'd3:    phase_coil = 4'b0110;
      3'd4:    phase_coil = 4'b0010;
      3'd5:    phase_coil = 4'b0011;
      3'd6:    phase_coil = 4'b0001;
      default: phase_coil = 4'b1001;
    endcase
  endfunction

  // Debounce bit layout: dir at [N-1:0], enable at [2N-1:N], limit at [3N-1:2N].
  logic [NDB-1:0]               raw;
  logic [NDB-1:0]               db_q, db_d;
  logic [NDB-1:0][DB_W-1:0]     db_cnt_q, db_cnt_d;
  logic [PRE_W-1:0]             pre_q, pre_d;
  logic [NUM_AXES-1:0][2:0]     phase_q, phase_d;
  logic [NUM_AXES-1:0][POS_W-1:0] pos_q, pos_d;
  logic [NUM_AXES-1:0][3:0]     coil_q, coil_d;
  logic [NUM_AXES-1:0]          moving_q, moving_d;
  logic [NUM_AXES-1:0]          homed_q, homed_d;

  logic             tick;
  logic             en_a, dir_a, lim_a, step_a;
  logic [POS_W-1:0] base_a;
  logic [2:0]       delta_a, nxt_a;

  assign raw = {lim_in, en_in, dir_in};

  // Counter runs only while raw disagrees with the debounced value.
  always_comb begin
    db_d     = db_q;
    db_cnt_d = '0;
    for (int i = 0; i < NDB; i++) begin
      if (raw[i] != db_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          db_d[i] = raw[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    tick     = (pre_q == PRE_LAST);
    pre_d    = tick ? '0 : pre_q + 1'b1;
    phase_d  = phase_q;
    pos_d    = pos_q;
    moving_d = moving_q;
    homed_d  = homed_q;
    coil_d   = '0;
    en_a     = 1'b0;
    dir_a    = 1'b0;
    lim_a    = 1'b0;
    step_a   = 1'b0;
    base_a   = '0;
    delta_a  = 3'd0;
    nxt_a    = 3'd0;
    for (int a = 0; a < NUM_AXES; a++) begin
      en_a   = db_q[NUM_AXES + a];
      dir_a  = db_q[a];
      lim_a  = db_q[2*NUM_AXES + a];
      // A pressed limit pins the position at home every cycle; a forward step
      // taken on the switch therefore counts from zero.
      base_a = lim_a ? '0 : pos_q[a];
      pos_d[a] = base_a;
      if (lim_a) begin
        homed_d[a] = 1'b1;
      end
      if (tick) begin
        step_a = en_a && !(!dir_a && lim_a) && !(dir_a && (base_a == POS_MAX));
        moving_d[a] = step_a;
        if (step_a) begin
          delta_a = half_step ? 3'd1 : 3'd2;
          nxt_a   = dir_a ? phase_q[a] + delta_a : phase_q[a] - delta_a;
          // Full-step forces an even phase so an odd one left by half mode realigns.
          phase_d[a] = half_step ? nxt_a : (nxt_a & 3'b110);
          pos_d[a]   = dir_a ? base_a + 1'b1 : base_a - 1'b1;
        end
      end
      // Built from next-state values so the coil register matches phase/enable.
      coil_d[a] = db_d[NUM_AXES + a] ? phase_coil(phase_d[a]) : 4'b0000;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      db_q     <= '0;
      db_cnt_q <= '0;
      pre_q    <= '0;
      phase_q  <= '0;
      pos_q    <= '0;
      coil_q   <= '0;
      moving_q <= '0;
      homed_q  <= '0;
    end else begin
      db_q     <= db_d;
      db_cnt_q <= db_cnt_d;
      pre_q    <= pre_d;
      phase_q  <= phase_d;
      pos_q    <= pos_d;
      coil_q   <= coil_d;
      moving_q <= moving_d;
      homed_q  <= homed_d;
    end
  end

  assign coil   = coil_q;
  assign pos    = pos_q;
  assign moving = moving_q;
  assign homed  = homed_q;

endmodule
